// File: rtl/fact_mul_ctrl_if.sv
// Handshake bundle between the factorial sequencer, its requester
// and the shared multiplier.
interface fact_mul_ctrl_if #(
    parameter int W = 64
);
    logic           op_start;
    logic           op_clear;
    logic [W-1:0]   n_value;
    logic [W-1:0]   result;
    logic           op_done;
    logic           overflow;
    logic           busy;
    logic           mul_clear;
    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_done;
    logic [2*W-1:0] mul_result;

    // Sequencer side: serves op requests, drives the multiplier.
    modport slave (
        input  op_start,
        input  op_clear,
        input  n_value,
        input  mul_done,
        input  mul_result,
        output result,
        output op_done,
        output overflow,
        output busy,
        output mul_clear,
        output mul_start,
        output mul_a,
        output mul_b
    );

    // Environment side: requester plus multiplier.
    modport master (
        output op_start,
        output op_clear,
        output n_value,
        output mul_done,
        output mul_result,
        input  result,
        input  op_done,
        input  overflow,
        input  busy,
        input  mul_clear,
        input  mul_start,
        input  mul_a,
        input  mul_b
    );
endinterface

// File: rtl/fact_mul_ctrl.sv
// N! sequencer: walks a down-counter through the shared multiplier,
// one clear/start/done handshake per factor.
module fact_mul_ctrl #(
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    fact_mul_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic         hi_nz;

    assign hi_nz = (bus.mul_result[2*W-1:W] != '0);

    // State, running product, counter and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state; op_clear overrides every state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (bus.op_clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.op_start) begin
                        acc_d = W'(1);
                        cnt_d = bus.n_value;
                        ovf_d = 1'b0;
                        if (bus.n_value <= W'(1))
                            state_d = S_DONE;
                        else
                            state_d = S_CLEAR;
                    end
                end
                S_CLEAR: state_d = S_START;
                S_START: state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.mul_done) begin
                        acc_d = bus.mul_result[W-1:0];
                        cnt_d = cnt_q - W'(1);
                        if (hi_nz) begin
                            ovf_d   = 1'b1;
                            state_d = S_DONE;
                        end else if (cnt_q == W'(2)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CLEAR;
                        end
                    end
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore outputs, except the op_clear pass-through on mul_clear,
    // which is suppressed while reset is held.
    assign bus.mul_clear = reset_n &
                           ((state_q == S_CLEAR) | bus.op_clear);
    assign bus.mul_start = (state_q == S_START);
    assign bus.op_done   = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_CLEAR) |
                           (state_q == S_START) |
                           (state_q == S_WAIT);
    assign bus.result    = acc_q;
    assign bus.overflow  = ovf_q;
    assign bus.mul_a     = acc_q;
    assign bus.mul_b     = cnt_q;

endmodule

// File: tb/tb_fact_mul_ctrl.sv
// Bench for fact_mul_ctrl: directed scenarios plus random N/latency
// runs against an arithmetic factorial model.
module tb_fact_mul_ctrl;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    fact_mul_ctrl_if #(.W(64)) bif ();
    fact_mul_ctrl_if #(.W(8))  b8 ();

    fact_mul_ctrl #(.W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave)
    );

    fact_mul_ctrl #(.W(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b8.slave)
    );

    int checks = 0;
    int errors = 0;

    // Multiplier model (64-bit), latency lat WAIT cycles.
    int           lat = 3;
    int           mdly;
    logic [127:0] prod;

    assign bif.mul_done   = (mdly == 1);
    assign bif.mul_result = prod;

    // Multiply accepted on mul_start, done after lat cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdly <= 0;
            prod <= '0;
        end else if (bif.mul_clear) begin
            mdly <= 0;
        end else if (bif.mul_start) begin
            mdly <= lat;
            prod <= {64'd0, bif.mul_a} * {64'd0, bif.mul_b};
        end else if (mdly != 0) begin
            mdly <= mdly - 1;
        end
    end

    // Multiplier model (8-bit), fixed latency 1.
    int          mdly8;
    logic [15:0] prod8;

    assign b8.mul_done   = (mdly8 == 1);
    assign b8.mul_result = prod8;

    // Same model for the narrow instance.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdly8 <= 0;
            prod8 <= '0;
        end else if (b8.mul_clear) begin
            mdly8 <= 0;
        end else if (b8.mul_start) begin
            mdly8 <= 1;
            prod8 <= {8'd0, b8.mul_a} * {8'd0, b8.mul_b};
        end else if (mdly8 != 0) begin
            mdly8 <= mdly8 - 1;
        end
    end

    // Monitors: operand pairs at each start, pulse counters.
    logic [127:0] mq[$];
    int nclr  = 0;
    int ndone = 0;
    int n8s   = 0;

    // Record handshake activity seen at each edge.
    always @(posedge clk) begin
        if (bif.mul_start)
            mq.push_back({bif.mul_a, bif.mul_b});
        if (bif.mul_clear)
            nclr <= nclr + 1;
        if (bif.op_done)
            ndone <= ndone + 1;
        if (b8.mul_start)
            n8s <= n8s + 1;
    end

    logic [127:0] epairs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Factorial from the definition, multiplying N, N-1, ... 2
    // into a W-bit accumulator and stopping at the first overflow.
    task automatic ref_fact(input logic [63:0] n,
                            output logic [63:0] r,
                            output bit ov,
                            output int k);
        logic [127:0] p;
        r  = 64'd1;
        ov = 1'b0;
        k  = 0;
        epairs.delete();
        for (longint unsigned i = n; i > 1 && !ov; i--) begin
            epairs.push_back({r, 64'(i)});
            p  = {64'd0, r} * {64'd0, 64'(i)};
            r  = p[63:0];
            ov = (p[127:64] != 0);
            k++;
        end
    endtask

    task automatic run(input logic [63:0] n,
                       input int l,
                       input bit poke);
        logic [63:0] r;
        bit ov;
        int k, cyc, s0, c0, ecyc;
        ref_fact(n, r, ov, k);
        ecyc = (n <= 1) ? 1 : 1 + k * (2 + l);
        lat = l;
        s0 = mq.size();
        c0 = nclr;
        bif.n_value  = n;
        bif.op_start = 1'b1;
        tick();
        bif.op_start = 1'b0;
        cyc = 1;
        while (bif.op_done !== 1'b1 && cyc < 5000) begin
            if (poke && cyc == 4) begin
                bif.op_start = 1'b1;
                bif.n_value  = n + 3;
            end else begin
                bif.op_start = 1'b0;
            end
            tick();
            cyc++;
        end
        bif.op_start = 1'b0;
        chk("done_cycle", 128'(cyc), 128'(ecyc));
        chk("result", bif.result, r);
        chk("overflow", bif.overflow, ov);
        chk("start_pulses", 128'(mq.size() - s0), 128'(k));
        chk("clear_pulses", 128'(nclr - c0), 128'(k));
        for (int j = 0; j < k && s0 + j < mq.size(); j++)
            chk("operands", mq[s0 + j], epairs[j]);
    endtask

    task automatic do_clear();
        bif.op_clear = 1'b1;
        tick();
        bif.op_clear = 1'b0;
        chk("clr_done", bif.op_done, 1'b0);
        chk("clr_busy", bif.busy, 1'b0);
        chk("clr_result", bif.result, 64'd0);
    endtask

    initial begin
        int g, d0;
        reset_n = 1'b0;
        bif.op_start = 1'b0;
        bif.op_clear = 1'b0;
        bif.n_value  = '0;
        b8.op_start  = 1'b0;
        b8.op_clear  = 1'b0;
        b8.n_value   = '0;
        #2;
        chk("rst_result", bif.result, 64'd0);
        chk("rst_done", bif.op_done, 1'b0);
        chk("rst_ovf", bif.overflow, 1'b0);
        chk("rst_busy", bif.busy, 1'b0);
        chk("rst_mstart", bif.mul_start, 1'b0);
        chk("rst_mclear", bif.mul_clear, 1'b0);
        chk("rst_a", bif.mul_a, 64'd0);
        chk("rst_b", bif.mul_b, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // N=5, L=3: DONE at cycle 21 with 120.
        run(64'd5, 3, 1'b0);
        do_clear();
        run(64'd0, 2, 1'b0);
        do_clear();
        run(64'd1, 2, 1'b0);
        do_clear();

        // op_clear together with mul_done in WAIT.
        lat = 3;
        d0 = ndone;
        bif.n_value  = 64'd5;
        bif.op_start = 1'b1;
        tick();
        bif.op_start = 1'b0;
        g = 0;
        while (bif.mul_done !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        chk("abort_reached_done", bif.mul_done, 1'b1);
        bif.op_clear = 1'b1;
        #1;
        chk("abort_mclear", bif.mul_clear, 1'b1);
        tick();
        bif.op_clear = 1'b0;
        chk("abort_busy", bif.busy, 1'b0);
        chk("abort_acc", bif.result, 64'd0);
        chk("abort_no_done", 128'(ndone - d0), 128'd0);
        run(64'd3, 2, 1'b0);
        do_clear();

        // op_start during WAIT and during DONE is ignored.
        run(64'd4, 3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            bif.op_start = i[0];
            bif.n_value  = 64'd9;
            tick();
            chk("hold_result", bif.result, 64'd24);
            chk("hold_done", bif.op_done, 1'b1);
        end
        bif.op_start = 1'b0;
        do_clear();

        // op_clear beats op_start in IDLE.
        bif.op_start = 1'b1;
        bif.op_clear = 1'b1;
        bif.n_value  = 64'd4;
        tick();
        bif.op_start = 1'b0;
        bif.op_clear = 1'b0;
        tick();
        chk("idle_prio_busy", bif.busy, 1'b0);
        chk("idle_prio_done", bif.op_done, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        lat = 3;
        bif.n_value  = 64'd10;
        bif.op_start = 1'b1;
        tick();
        bif.op_start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", bif.busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_result", bif.result, 64'd0);
        chk("arst_busy", bif.busy, 1'b0);
        chk("arst_done", bif.op_done, 1'b0);
        chk("arst_mclear", bif.mul_clear, 1'b0);
        chk("arst_mstart", bif.mul_start, 1'b0);
        chk("arst_ab", {bif.mul_a, bif.mul_b}, 128'd0);
        tick();
        reset_n = 1'b1;
        tick();
        run(64'd4, 2, 1'b0);
        do_clear();

        // Narrow instance: 6! overflows 8 bits at 360.
        b8.n_value  = 8'd6;
        b8.op_start = 1'b1;
        tick();
        b8.op_start = 1'b0;
        g = 0;
        while (b8.mul_done !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        tick();
        chk("w8_first", b8.result, 8'd6);
        chk("w8_first_ovf", b8.overflow, 1'b0);
        g = 0;
        while (b8.op_done !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        chk("w8_result", b8.result, 8'd104);
        chk("w8_ovf", b8.overflow, 1'b1);
        chk("w8_starts", 128'(n8s), 128'd4);
        b8.op_clear = 1'b1;
        tick();
        b8.op_clear = 1'b0;
        chk("w8_clr_ovf", b8.overflow, 1'b0);

        // Random N and multiplier latency.
        for (int i = 0; i < 10; i++) begin
            run(64'($urandom_range(0, 25)),
                int'($urandom_range(1, 4)), 1'(i % 3 == 0));
            do_clear();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
